mem_port_b_arbiter: RTL and testbench
=====================================

# mem_port_b_arbiter

Shares the system RAM's second port between two requesters. The VGA glyph/text fetcher has priority; an auxiliary master (sprite/DMA loader, debug reader) gets the port when VGA is idle or when its starvation counter expires. Sits between the RAM port-B pins (address, write enable, write data, read data) and the two masters. Tracks in-flight reads so that each returned word is steered to the master that issued it.

## Interface
Parameters:
- ADDR_WIDTH, 16, port-B address width
- DATA_WIDTH, 16, port-B data width
- RD_LATENCY, 1, RAM read latency in cycles, from address presented to mem_rdata valid; legal range 1..4
- MAX_WAIT, 8, consecutive denied cycles after which aux is forced a grant; legal range 1..255

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- vga_req  in  1  VGA read request, held until granted
- vga_addr  in  ADDR_WIDTH  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_rvalid  out  1  vga_rdata valid
- vga_rdata  out  DATA_WIDTH  VGA read data
- aux_req  in  1  aux request, held with addr/we/wdata stable until granted
- aux_addr  in  ADDR_WIDTH  aux address
- aux_we  in  1  1 = write, 0 = read
- aux_wdata  in  DATA_WIDTH  aux write data
- aux_gnt  out  1  aux request accepted this cycle
- aux_rvalid  out  1  aux_rdata valid
- aux_rdata  out  DATA_WIDTH  aux read data
- mem_addr  out  ADDR_WIDTH  RAM port-B address
- mem_we  out  1  RAM port-B write enable
- mem_wdata  out  DATA_WIDTH  RAM port-B write data
- mem_rdata  in  DATA_WIDTH  RAM port-B read data

## Operation
- Grant decision is combinational from the requests and wait_cnt. At most one gnt per cycle.
- Decision order:
  - If aux_req && wait_cnt == MAX_WAIT: aux granted (forced).
  - Else if vga_req: VGA granted.
  - Else if aux_req: aux granted.
  - Else: no grant.
- The granted master drives mem_addr, mem_we and mem_wdata in the same cycle.
- With no grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- VGA never writes: mem_we = 0 on a VGA grant.
- wait_cnt:
  - Width is clog2(MAX_WAIT+1).
  - Increments, saturating at MAX_WAIT, in each cycle where aux_req=1 and aux_gnt=0.
  - Clears to 0 on aux_gnt or when aux_req=0.
- Tag pipeline:
  - Depth RD_LATENCY. Each granted read shifts in a tag: NONE, VGA or AUX.
  - A write or an idle cycle shifts in NONE.
- Read return:
  - When the tag at the pipe output is VGA: vga_rvalid=1 and vga_rdata=mem_rdata.
  - When it is AUX: aux_rvalid=1 and aux_rdata=mem_rdata.
  - When it is NONE: both rvalid=0.
- rdata outputs are registered and hold their last value while rvalid=0.
- A write completes in the cycle it is granted and produces no rvalid.

## Timing
- Reset values:
  - vga_gnt, aux_gnt, mem_we, mem_addr, mem_wdata = 0.
  - vga_rvalid, aux_rvalid = 0; vga_rdata, aux_rdata = 0.
  - wait_cnt = 0; all tags = NONE.
- Read latency: grant in cycle N gives rvalid in cycle N+RD_LATENCY. Fully pipelined, one read per cycle.
- Reset asserted with reads in flight: the tag pipe is cleared. No rvalid is issued for those reads after reset, even when reset is a single cycle.
- Simultaneous requests: VGA wins unless wait_cnt == MAX_WAIT. Aux therefore waits at most MAX_WAIT cycles under continuous VGA traffic.
- The cycle after a forced aux grant, wait_cnt = 0 and VGA regains priority.
- A request dropped before grant is legal and is discarded. wait_cnt clears in that case.
- gnt is valid during the request cycle. A master may change addr or request a new access on the next edge.

## Structure
- Shared package holds:
  - the tag encoding: TAG_NONE=2'd0, TAG_VGA=2'd1, TAG_AUX=2'd2
  - default ADDR_WIDTH and DATA_WIDTH for the system bus
- One sub-module, read_tag_pipe: parameterised depth, 2-bit tag shift register with synchronous clear.
- Grant logic, wait counter and return steering live in the top.

## Test plan
- Only vga_req=1, addr 0x0040..0x0043 on consecutive cycles, RD_LATENCY=1 -> vga_gnt=1 every cycle; vga_rvalid one cycle later each time with matching RAM words; aux outputs quiet.
- vga_req held at 1 and aux_req=1 (read 0x1234), MAX_WAIT=8 -> aux_gnt first asserts on the 9th cycle, in which vga_gnt=0; aux_rvalid returns mem[0x1234]; VGA is granted again the following cycle.
- Aux write 0x00FF to 0x2000 with VGA idle -> mem_we=1, mem_addr=0x2000, mem_wdata=0x00FF for one cycle; no aux_rvalid; a later aux read of 0x2000 returns 0x00FF.
- Interleaved VGA/aux reads with RD_LATENCY=3 -> every rvalid arrives exactly 3 cycles after its grant, on the correct master, with no swaps.
- VGA read granted, then reset pulsed for 1 cycle before the return -> vga_rvalid stays 0; all outputs are 0 the cycle after reset.
- aux_req dropped after 5 denied cycles, then reasserted -> wait_cnt restarts from 0; the forced grant comes MAX_WAIT cycles after the reassertion.

Source files
------------

// File: rtl/mem_port_b_arbiter_pkg.sv
// Shared definitions for the RAM port-B arbiter: system bus widths and
// the read-return tag encoding carried through the tag pipeline.
package mem_port_b_arbiter_pkg;

    localparam int unsigned SYS_ADDR_WIDTH = 16;
    localparam int unsigned SYS_DATA_WIDTH = 16;

    // Owner of a read in flight; NONE marks writes and idle cycles.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_AUX  = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_VGA  = 2'd1,
        SEL_AUX  = 2'd2
    } sel_t;

endpackage

// File: rtl/mem_port_b_arbiter_read_tag_pipe.sv
// Fixed-depth shift register of read-return tags, matched to the RAM read
// latency so the tag at the output identifies the owner of mem_rdata.
module read_tag_pipe
    import mem_port_b_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic clear,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= TAG_NONE;
            end
        end else begin
            stages[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_b_arbiter.sv
// RAM port-B arbiter: VGA fetcher has priority, the aux master is served when
// VGA is idle or when its starvation counter saturates. Read data is steered by tag.
module mem_port_b_arbiter
    import mem_port_b_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SYS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SYS_DATA_WIDTH,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_gnt,
    output logic                  vga_rvalid,
    output logic [DATA_WIDTH-1:0] vga_rdata,
    input  logic                  aux_req,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic                  aux_we,
    input  logic [DATA_WIDTH-1:0] aux_wdata,
    output logic                  aux_gnt,
    output logic                  aux_rvalid,
    output logic [DATA_WIDTH-1:0] aux_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0]     wait_cnt;
    sel_t                  sel;
    tag_t                  tag_in;
    tag_t                  tag_out;
    logic [DATA_WIDTH-1:0] vga_rdata_q;
    logic [DATA_WIDTH-1:0] aux_rdata_q;

    // Grant decision; suppressed during reset so the port is quiet.
    always_comb begin
        sel = SEL_NONE;
        if (!reset) begin
            if (aux_req && (wait_cnt == WAIT_MAX)) begin
                sel = SEL_AUX;
            end else if (vga_req) begin
                sel = SEL_VGA;
            end else if (aux_req) begin
                sel = SEL_AUX;
            end
        end
    end

    always_comb begin
        vga_gnt   = 1'b0;
        aux_gnt   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        tag_in    = TAG_NONE;
        case (sel)
            SEL_VGA: begin
                vga_gnt  = 1'b1;
                mem_addr = vga_addr;
                tag_in   = TAG_VGA;
            end
            SEL_AUX: begin
                aux_gnt   = 1'b1;
                mem_addr  = aux_addr;
                mem_we    = aux_we;
                mem_wdata = aux_wdata;
                tag_in    = aux_we ? TAG_NONE : TAG_AUX;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!aux_req || aux_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    read_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .clear   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Returned word passes straight through on its valid cycle and is held
    // afterwards, so rvalid lines up exactly RD_LATENCY cycles after the grant.
    always_comb begin
        vga_rvalid = !reset && (tag_out == TAG_VGA);
        aux_rvalid = !reset && (tag_out == TAG_AUX);
        vga_rdata  = reset ? '0 : (vga_rvalid ? mem_rdata : vga_rdata_q);
        aux_rdata  = reset ? '0 : (aux_rvalid ? mem_rdata : aux_rdata_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            if (vga_rvalid) vga_rdata_q <= mem_rdata;
            if (aux_rvalid) aux_rdata_q <= mem_rdata;
        end
    end

    a_single_grant: assert property (@(posedge clk) !(vga_gnt && aux_gnt));

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Bench for mem_port_b_arbiter: two instances (read latency 1 and 3) share the
// stimulus; read expectations go into per-instance queues checked by a monitor.
module tb_mem_port_b_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_req = 1'b0;
    logic [15:0] vga_addr = '0;
    logic        aux_req = 1'b0;
    logic [15:0] aux_addr = '0;
    logic        aux_we = 1'b0;
    logic [15:0] aux_wdata = '0;

    logic        a_vga_gnt, a_vga_rvalid, a_aux_gnt, a_aux_rvalid, a_mem_we;
    logic [15:0] a_vga_rdata, a_aux_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_vga_gnt, b_vga_rvalid, b_aux_gnt, b_aux_rvalid, b_mem_we;
    logic [15:0] b_vga_rdata, b_aux_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          master;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic [15:0] ram [0:65535];
    logic [15:0] a_dp [1];
    logic [15:0] b_dp [3];
    logic [15:0] written [logic [15:0]];

    always #5 clk = ~clk;

    mem_port_b_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .RD_LATENCY (1),
        .MAX_WAIT   (8)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (a_vga_gnt),
        .vga_rvalid (a_vga_rvalid),
        .vga_rdata  (a_vga_rdata),
        .aux_req    (aux_req),
        .aux_addr   (aux_addr),
        .aux_we     (aux_we),
        .aux_wdata  (aux_wdata),
        .aux_gnt    (a_aux_gnt),
        .aux_rvalid (a_aux_rvalid),
        .aux_rdata  (a_aux_rdata),
        .mem_addr   (a_mem_addr),
        .mem_we     (a_mem_we),
        .mem_wdata  (a_mem_wdata),
        .mem_rdata  (a_mem_rdata)
    );

    mem_port_b_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .RD_LATENCY (3),
        .MAX_WAIT   (8)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (b_vga_gnt),
        .vga_rvalid (b_vga_rvalid),
        .vga_rdata  (b_vga_rdata),
        .aux_req    (aux_req),
        .aux_addr   (aux_addr),
        .aux_we     (aux_we),
        .aux_wdata  (aux_wdata),
        .aux_gnt    (b_aux_gnt),
        .aux_rvalid (b_aux_rvalid),
        .aux_rdata  (b_aux_rdata),
        .mem_addr   (b_mem_addr),
        .mem_we     (b_mem_we),
        .mem_wdata  (b_mem_wdata),
        .mem_rdata  (b_mem_rdata)
    );

    function automatic logic [15:0] exp_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = exp_word(16'(i));
    end

    // RAM model: data read at the address edge, delivered RD_LATENCY cycles on.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        a_dp[0] <= ram[a_mem_addr];
        b_dp[0] <= ram[b_mem_addr];
        b_dp[1] <= b_dp[0];
        b_dp[2] <= b_dp[1];
        if (a_mem_we) ram[a_mem_addr] <= a_mem_wdata;
    end
    assign a_mem_rdata = a_dp[0];
    assign b_mem_rdata = b_dp[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_ret(input string who, input exp_t e, input logic vv, input logic av,
                             input logic [15:0] vd, input logic [15:0] ad);
        chk({who, "_ret_master"}, {30'd0, vv, av}, (e.master == 1) ? 32'd2 : 32'd1);
        chk({who, "_ret_data"}, (e.master == 1) ? vd : ad, e.data);
        chk({who, "_ret_cycle"}, cyc, e.due);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0 && qa[0].due < cyc) begin
            chk("A_missing_return", cyc, qa[0].due);
            void'(qa.pop_front());
        end
        if (a_vga_rvalid || a_aux_rvalid) begin
            if (qa.size() == 0) chk("A_unexpected_rvalid", {a_vga_rvalid, a_aux_rvalid}, 0);
            else begin
                e = qa.pop_front();
                check_ret("A", e, a_vga_rvalid, a_aux_rvalid, a_vga_rdata, a_aux_rdata);
            end
        end
        if (qb.size() > 0 && qb[0].due < cyc) begin
            chk("B_missing_return", cyc, qb[0].due);
            void'(qb.pop_front());
        end
        if (b_vga_rvalid || b_aux_rvalid) begin
            if (qb.size() == 0) chk("B_unexpected_rvalid", {b_vga_rvalid, b_aux_rvalid}, 0);
            else begin
                e = qb.pop_front();
                check_ret("B", e, b_vga_rvalid, b_aux_rvalid, b_vga_rdata, b_aux_rdata);
            end
        end
    end

    // One cycle: drive requests, check the combinational grant/bus against the
    // hand-chosen winner g (0 none, 1 VGA, 2 aux), queue any read return.
    task automatic do_cycle(input logic vr, input logic [15:0] va, input logic ar,
                            input logic [15:0] aa, input logic aw, input logic [15:0] ad,
                            input int g);
        logic [15:0] e_addr, e_wd, d;
        logic        e_we;
        vga_req = vr; vga_addr = va;
        aux_req = ar; aux_addr = aa; aux_we = aw; aux_wdata = ad;
        #1;
        e_addr = (g == 1) ? va : (g == 2) ? aa : 16'h0;
        e_we   = (g == 2) && aw;
        e_wd   = (g == 2) ? ad : 16'h0;
        chk("A_vga_gnt", a_vga_gnt, g == 1);
        chk("A_aux_gnt", a_aux_gnt, g == 2);
        chk("A_mem_addr", a_mem_addr, e_addr);
        chk("A_mem_we", a_mem_we, e_we);
        chk("A_mem_wdata", a_mem_wdata, e_wd);
        chk("B_vga_gnt", b_vga_gnt, g == 1);
        chk("B_aux_gnt", b_aux_gnt, g == 2);
        chk("B_mem_addr", b_mem_addr, e_addr);
        chk("B_mem_we", b_mem_we, e_we);
        chk("B_mem_wdata", b_mem_wdata, e_wd);
        if (g == 2 && aw) written[aa] = ad;
        if (g == 1 || (g == 2 && !aw)) begin
            d = written.exists(e_addr) ? written[e_addr] : exp_word(e_addr);
            qa.push_back('{g, d, cyc + 1});
            qb.push_back('{g, d, cyc + 3});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_A_gnt"}, {a_vga_gnt, a_aux_gnt}, 0);
        chk({tag, "_A_mem"}, {a_mem_we, a_mem_addr, a_mem_wdata}, 0);
        chk({tag, "_A_rvalid"}, {a_vga_rvalid, a_aux_rvalid}, 0);
        chk({tag, "_A_rdata"}, {a_vga_rdata, a_aux_rdata}, 0);
        chk({tag, "_B_gnt"}, {b_vga_gnt, b_aux_gnt}, 0);
        chk({tag, "_B_mem"}, {b_mem_we, b_mem_addr, b_mem_wdata}, 0);
        chk({tag, "_B_rvalid"}, {b_vga_rvalid, b_aux_rvalid}, 0);
        chk({tag, "_B_rdata"}, {b_vga_rdata, b_aux_rdata}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with requests pending: nothing may be granted.
        vga_req = 1'b1; vga_addr = 16'h1111;
        aux_req = 1'b1; aux_addr = 16'h2222; aux_we = 1'b1; aux_wdata = 16'h3333;
        @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // VGA-only burst, latency 1 and 3.
        for (int i = 0; i < 4; i++)
            do_cycle(1'b1, 16'h0040 + 16'(i), 1'b0, 16'h0, 1'b0, 16'h0, 1);
        idle(4);
        chk("A_vga_rdata_hold", a_vga_rdata, exp_word(16'h0043));
        chk("B_vga_rdata_hold", b_vga_rdata, exp_word(16'h0043));
        chk("A_aux_rdata_quiet", a_aux_rdata, 16'h0);

        // Starved aux read forced on the 9th cycle under continuous VGA traffic.
        for (int i = 1; i <= 8; i++)
            do_cycle(1'b1, 16'h0800 + 16'(i), 1'b1, 16'h1234, 1'b0, 16'h0, 1);
        do_cycle(1'b1, 16'h0809, 1'b1, 16'h1234, 1'b0, 16'h0, 2);
        do_cycle(1'b1, 16'h0809, 1'b0, 16'h0, 1'b0, 16'h0, 1);
        idle(4);

        // Aux write, then read back.
        do_cycle(1'b0, 16'h0, 1'b1, 16'h2000, 1'b1, 16'h00FF, 2);
        idle(1);
        do_cycle(1'b0, 16'h0, 1'b1, 16'h2000, 1'b0, 16'h0, 2);
        idle(4);
        chk("A_aux_readback_hold", a_aux_rdata, 16'h00FF);
        chk("B_aux_readback_hold", b_aux_rdata, 16'h00FF);

        // Interleaved masters.
        do_cycle(1'b1, 16'h0100, 1'b0, 16'h0,    1'b0, 16'h0, 1);
        do_cycle(1'b0, 16'h0,    1'b1, 16'h0200, 1'b0, 16'h0, 2);
        do_cycle(1'b1, 16'h0101, 1'b1, 16'h0201, 1'b0, 16'h0, 1);
        do_cycle(1'b0, 16'h0,    1'b1, 16'h0201, 1'b0, 16'h0, 2);
        do_cycle(1'b1, 16'h0102, 1'b0, 16'h0,    1'b0, 16'h0, 1);
        do_cycle(1'b0, 16'h0,    1'b1, 16'h0202, 1'b0, 16'h0, 2);
        idle(4);

        // Single-cycle reset with a VGA read in flight: its return is dropped.
        do_cycle(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0, 16'h0, 1);
        qa.delete();
        qb.delete();
        reset = 1'b1;
        vga_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("post_reset");
        @(posedge clk);
        #1;
        idle(4);

        // Aux drops after 5 denials; the counter restarts on reassertion.
        for (int i = 1; i <= 5; i++)
            do_cycle(1'b1, 16'h0500 + 16'(i), 1'b1, 16'h3000, 1'b0, 16'h0, 1);
        do_cycle(1'b1, 16'h0506, 1'b0, 16'h3000, 1'b0, 16'h0, 1);
        for (int i = 1; i <= 8; i++)
            do_cycle(1'b1, 16'h0506 + 16'(i), 1'b1, 16'h3000, 1'b0, 16'h0, 1);
        do_cycle(1'b1, 16'h050F, 1'b1, 16'h3000, 1'b0, 16'h0, 2);
        do_cycle(1'b1, 16'h050F, 1'b0, 16'h0, 1'b0, 16'h0, 1);
        idle(5);

        chk("A_queue_drained", qa.size(), 0);
        chk("B_queue_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
